// File: rtl/apb_master_bridge.sv
// APB requester: turns single 8-bit valid/ready commands into one APB transfer
// (SETUP then ACCESS) on PSEL1 (GPIO) or PSEL2 (UART), with an ACCESS-phase timeout.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic       req_sel,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic [7:0] PADDR,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;

  assign req_ready = (state == IDLE) && !PRESET;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            PADDR    <= req_addr;
            PWDATA   <= req_wdata;
            PWRITE   <= req_write;
            PSEL1    <= !req_sel;
            PSEL2    <= req_sel;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= PWRITE ? 8'h00 : PRDATA;
            state     <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            // abort on the TIMEOUT-th low edge; counter already holds TIMEOUT-1
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level model checked every cycle,
// directed literal scenarios followed by randomized commands and slave behaviour.
module tb_apb_master_bridge;
  localparam int unsigned TO = 4;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       req_valid = 1'b0, req_write = 1'b0, req_sel = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA = '0;
  logic       PREADY = 1'b0;

  int passed = 0;
  int total  = 0;

  apb_master_bridge #(.TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Transaction-level model: a command is "busy" from acceptance until it
  // completes; age counts edges since acceptance, lows counts wait edges.
  logic       m_ok = 1'b0;
  logic       busy = 1'b0;
  int         age = 0, lows = 0;
  logic       e_psel1 = 0, e_psel2 = 0, e_pen = 0, e_pwrite = 0;
  logic [7:0] e_paddr = 0, e_pwdata = 0, e_rdata = 0;
  logic       e_rv = 0, e_err = 0;

  always @(posedge PCLK) begin
    m_ok = 1'b1;
    if (PRESET) begin
      busy = 0; e_psel1 = 0; e_psel2 = 0; e_pen = 0; e_pwrite = 0;
      e_paddr = 0; e_pwdata = 0; e_rdata = 0; e_rv = 0; e_err = 0;
    end else begin
      e_rv = 0;
      if (!busy) begin
        if (req_valid) begin
          busy = 1; age = 1; lows = 0;
          e_paddr = req_addr; e_pwdata = req_wdata; e_pwrite = req_write;
          e_psel1 = !req_sel; e_psel2 = req_sel;
        end
      end else begin
        age++;
        if (age == 2) e_pen = 1;
        else begin
          if (PREADY || lows + 1 == int'(TO)) begin
            e_err   = !PREADY;
            e_rdata = (PREADY && !e_pwrite) ? PRDATA : 8'h00;
            e_rv = 1; busy = 0; e_psel1 = 0; e_psel2 = 0; e_pen = 0;
          end else lows++;
        end
      end
    end
  end

  always @(negedge PCLK) begin
    if (m_ok) begin
      chk("req_ready", req_ready, !busy && !PRESET);
      chk("psel1", PSEL1, e_psel1);
      chk("psel2", PSEL2, e_psel2);
      chk("penable", PENABLE, e_pen);
      chk("paddr", PADDR, e_paddr);
      chk("pwrite", PWRITE, e_pwrite);
      chk("pwdata", PWDATA, e_pwdata);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err", rsp_err, e_err);
      chk("psel_excl", PSEL1 & PSEL2, 0);
    end
  end

  task automatic step();
    @(posedge PCLK);
    #2;
  endtask

  task automatic cmd(input logic w, input logic s, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1; req_write = w; req_sel = s; req_addr = a; req_wdata = d;
  endtask

  initial begin
    step(); step();
    chk("rst_psel", {PSEL1, PSEL2, PENABLE, PWRITE}, 4'h0);
    chk("rst_bus", {PADDR, PWDATA}, 16'h0000);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h000);
    PRESET = 0;

    // UART write, zero wait states
    PREADY = 1; cmd(1, 1, 8'h04, 8'hA5);
    step(); req_valid = 0;
    chk("w_setup", {PSEL1, PSEL2, PENABLE}, 3'b010);
    chk("w_paddr", PADDR, 8'h04);
    step();
    chk("w_access", {PSEL2, PENABLE, PWRITE}, 3'b111);
    chk("w_pwdata", PWDATA, 8'hA5);
    step();
    chk("w_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h200);
    chk("w_idle", {PSEL1, PSEL2, PENABLE, req_ready}, 4'b0001);
    step();
    chk("w_rsp_once", rsp_valid, 0);

    // GPIO read with 3 wait states
    PREADY = 0; cmd(0, 0, 8'h10, 8'h00);
    step(); req_valid = 0;
    chk("r_setup", {PSEL1, PSEL2, PENABLE}, 3'b100);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_wait", {PENABLE, rsp_valid, PADDR}, {2'b10, 8'h10});
    end
    PREADY = 1; PRDATA = 8'h3C;
    step();
    chk("r_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 8'h3C});

    // timeout with PREADY stuck low
    PREADY = 0; cmd(0, 1, 8'h08, 8'h00);
    step(); req_valid = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t_wait", {PSEL2, PENABLE, rsp_valid}, 3'b110);
    end
    step();
    chk("t_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 8'h00});
    chk("t_drop", {PSEL1, PSEL2, PENABLE}, 3'b000);

    // back-to-back with req_valid held
    PREADY = 1; PRDATA = 8'h99; cmd(1, 0, 8'h21, 8'h11);
    step(); cmd(0, 1, 8'h22, 8'h00);
    step();
    chk("b_busy", {req_ready, PSEL1, PADDR}, {2'b01, 8'h21});
    step();
    chk("b_rspA", {rsp_valid, rsp_rdata, req_ready}, {1'b1, 8'h00, 1'b1});
    step(); req_valid = 0; PRDATA = 8'h77;
    chk("b_acceptB", {PSEL2, PWRITE, PADDR}, {2'b10, 8'h22});
    step(); PRDATA = 8'h5A;
    step();
    chk("b_rspB", {rsp_valid, rsp_rdata}, {1'b1, 8'h5A});

    // reset during ACCESS, with a command presented alongside reset
    PREADY = 0; cmd(1, 0, 8'h30, 8'h44);
    step(); req_valid = 0;
    step(); step();
    PRESET = 1; cmd(1, 1, 8'h31, 8'h55);
    step();
    chk("x_rst", {PSEL1, PSEL2, PENABLE, rsp_valid, PADDR, PWDATA}, 20'h0);
    chk("x_ready", req_ready, 0);
    PRESET = 0; req_valid = 0;
    step();
    chk("x_noacc", {PSEL1, PSEL2}, 2'b00);
    PREADY = 1; cmd(0, 0, 8'h32, 8'h00); PRDATA = 8'hC3;
    step(); req_valid = 0;
    step(); step();
    chk("x_fresh", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 8'hC3});

    // randomized commands and slave behaviour
    for (int n = 0; n < 600; n++) begin
      req_valid = ($urandom_range(0, 1) == 1);
      req_write = $urandom_range(0, 1);
      req_sel   = $urandom_range(0, 1);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      PRDATA    = 8'($urandom);
      PREADY    = ($urandom_range(0, 9) < 5);
      PRESET    = ($urandom_range(0, 99) == 0);
      step();
    end
    PRESET = 0; req_valid = 0;
    step(); step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
